// File: rtl/fnd_pkg.sv
// Shared types and constants for the 4-digit 7-segment scan controller.
package fnd_pkg;

  typedef enum logic {
    ST_SHOW,
    ST_BLANK
  } state_t;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [3:0] COM_OFF = 4'hF;

  // Active-low {dp,g,f,e,d,c,b,a}, entry n = glyph for hex n, dp off.
  localparam logic [15:0][7:0] SEG_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6,
    8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99,
    8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  function automatic logic [3:0] com_onehot(
    input logic [1:0] idx
  );
    com_onehot = ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/fnd_seg_decoder.sv
// Hex nibble to active-low segment pattern with dp and blanking.
module fnd_seg_decoder
  import fnd_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  input  logic       blank,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_TABLE[nibble];
    if (blank) seg[6:0] = 7'h7F;
    seg[7] = ~dp;
  end

endmodule

// File: rtl/fnd_scan_controller.sv
// Time-multiplexes four common-anode digits off an async scan clock,
// with anti-ghost blanking, per-frame snapshot and leading-zero blanking.
module fnd_scan_controller
  import fnd_pkg::*;
#(
  parameter int BLANK_CYCLES = 50,
  parameter int CNT_W        = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_scan_clk,
  input  logic [15:0] i_value,
  input  logic [3:0]  i_dp,
  input  logic        i_lz_blank,
  output logic [3:0]  o_com,
  output logic [7:0]  o_seg,
  output logic        o_frame
);

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(BLANK_CYCLES - 1);

  logic s1, s2, s3;
  logic scan_edge;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [1:0]       idx, idx_nx;
  logic [3:0]       com_nx;
  logic [7:0]       seg_nx;
  logic             frame_nx;

  logic [15:0] snap_value, snap_value_nx;
  logic [3:0]  snap_dp, snap_dp_nx;
  logic        snap_lz, snap_lz_nx;

  logic [1:0]  idx_inc;
  logic        use_in;
  logic [15:0] src_value;
  logic [3:0]  src_dp;
  logic        src_lz;
  logic [3:0]  nib;
  logic [3:0]  zero;
  logic        lz_hit;
  logic [7:0]  dec_seg;

  assign scan_edge = s2 & ~s3;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= i_scan_clk;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Digit 0 starts a frame: it reads live inputs, others the snapshot.
  assign idx_inc   = idx + 2'd1;
  assign use_in    = (idx_inc == 2'd0);
  assign src_value = use_in ? i_value : snap_value;
  assign src_dp    = use_in ? i_dp : snap_dp;
  assign src_lz    = use_in ? i_lz_blank : snap_lz;
  assign nib       = src_value[{idx_inc, 2'b00} +: 4];

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      zero[k] = (src_value[4*k +: 4] == 4'h0);
    end
  end

  always_comb begin
    lz_hit = 1'b0;
    unique case (idx_inc)
      2'd3: lz_hit = zero[3];
      2'd2: lz_hit = zero[3] & zero[2];
      2'd1: lz_hit = zero[3] & zero[2] & zero[1];
      2'd0: lz_hit = 1'b0;
    endcase
  end

  fnd_seg_decoder u_dec (
    .nibble (nib),
    .dp     (src_dp[idx_inc]),
    .blank  (src_lz & lz_hit),
    .seg    (dec_seg)
  );

  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt;
    idx_nx        = idx;
    com_nx        = o_com;
    seg_nx        = o_seg;
    frame_nx      = 1'b0;
    snap_value_nx = snap_value;
    snap_dp_nx    = snap_dp;
    snap_lz_nx    = snap_lz;
    if (scan_edge) begin
      state_nx = ST_BLANK;
      cnt_nx   = '0;
      com_nx   = COM_OFF;
      seg_nx   = SEG_OFF;
    end else begin
      unique case (state)
        ST_BLANK: begin
          if (cnt == CNT_LAST) begin
            state_nx = ST_SHOW;
            idx_nx   = idx_inc;
            com_nx   = com_onehot(idx_inc);
            seg_nx   = dec_seg;
            if (use_in) begin
              frame_nx      = 1'b1;
              snap_value_nx = i_value;
              snap_dp_nx    = i_dp;
              snap_lz_nx    = i_lz_blank;
            end
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        ST_SHOW: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state      <= ST_BLANK;
      cnt        <= '0;
      idx        <= 2'd3;
      o_com      <= COM_OFF;
      o_seg      <= SEG_OFF;
      o_frame    <= 1'b0;
      snap_value <= '0;
      snap_dp    <= '0;
      snap_lz    <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      idx        <= idx_nx;
      o_com      <= com_nx;
      o_seg      <= seg_nx;
      o_frame    <= frame_nx;
      snap_value <= snap_value_nx;
      snap_dp    <= snap_dp_nx;
      snap_lz    <= snap_lz_nx;
    end
  end

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Directed bench for fnd_scan_controller with BLANK_CYCLES=4.
module tb_fnd_scan_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        scan;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        lz;
  logic [3:0]  com;
  logic [7:0]  seg;
  logic        frame;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fnd_scan_controller #(
    .BLANK_CYCLES (4),
    .CNT_W        (8)
  ) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_scan_clk (scan),
    .i_value    (value),
    .i_dp       (dp),
    .i_lz_blank (lz),
    .o_com      (com),
    .o_seg      (seg),
    .o_frame    (frame)
  );

  task automatic chk(
    input string      tag,
    input logic [7:0] obs,
    input logic [7:0] exp
  );
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_off(input string tag);
    chk({tag, "_com_off"}, {4'h0, com}, 8'h0F);
    chk({tag, "_seg_off"}, seg, 8'hFF);
  endtask

  task automatic chk_show(
    input string      tag,
    input logic [3:0] ecom,
    input logic [7:0] eseg,
    input logic       efr
  );
    chk({tag, "_com"}, {4'h0, com}, {4'h0, ecom});
    chk({tag, "_seg"}, seg, eseg);
    chk({tag, "_frame"}, {7'h0, frame}, {7'h0, efr});
  endtask

  // Raise scan, expect 4 blank cycles, then the digit; then drop scan.
  task automatic scan_digit(
    input string      tag,
    input logic [3:0] ecom,
    input logic [7:0] eseg,
    input logic       efr
  );
    scan = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    repeat (4) begin
      @(posedge clk); #1;
      chk_off(tag);
    end
    @(posedge clk); #1;
    chk_show(tag, ecom, eseg, efr);
    @(posedge clk); #1;
    chk({tag, "_frame_end"}, {7'h0, frame}, 8'h00);
    repeat (18) @(posedge clk);
    #1;
    scan = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk({tag, "_hold"}, seg, eseg);
  endtask

  initial begin
    rst   = 1'b1;
    scan  = 1'b0;
    value = 16'h1234;
    dp    = 4'h0;
    lz    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_show("reset", 4'hF, 8'hFF, 1'b0);
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk_off("boot");
    end
    @(posedge clk); #1;
    chk_show("boot_d0", 4'b1110, 8'h99, 1'b1);
    @(posedge clk); #1;
    chk("boot_frame_end", {7'h0, frame}, 8'h00);
    repeat (20) @(posedge clk);
    #1;

    scan_digit("s2_d1", 4'b1101, 8'hB0, 1'b0);
    scan_digit("s2_d2", 4'b1011, 8'hA4, 1'b0);
    scan_digit("s2_d3", 4'b0111, 8'hF9, 1'b0);
    scan_digit("s2_d0", 4'b1110, 8'h99, 1'b1);

    scan_digit("s3_d1", 4'b1101, 8'hB0, 1'b0);
    value = 16'h5678;
    scan_digit("s3_d2", 4'b1011, 8'hA4, 1'b0);
    scan_digit("s3_d3", 4'b0111, 8'hF9, 1'b0);
    scan_digit("s3_d0", 4'b1110, 8'h80, 1'b1);
    scan_digit("s3_d1n", 4'b1101, 8'hF8, 1'b0);

    value = 16'h0050;
    lz    = 1'b1;
    scan_digit("s4_old_d2", 4'b1011, 8'h82, 1'b0);
    scan_digit("s4_old_d3", 4'b0111, 8'h92, 1'b0);
    scan_digit("s4_lz_d0", 4'b1110, 8'hC0, 1'b1);
    scan_digit("s4_lz_d1", 4'b1101, 8'h92, 1'b0);
    scan_digit("s4_lz_d2", 4'b1011, 8'hFF, 1'b0);
    scan_digit("s4_lz_d3", 4'b0111, 8'hFF, 1'b0);
    lz = 1'b0;
    scan_digit("s4_nz_d0", 4'b1110, 8'hC0, 1'b1);
    scan_digit("s4_nz_d1", 4'b1101, 8'h92, 1'b0);
    scan_digit("s4_nz_d2", 4'b1011, 8'hC0, 1'b0);
    scan_digit("s4_nz_d3", 4'b0111, 8'hC0, 1'b0);

    value = 16'h1234;
    dp    = 4'b0010;
    scan_digit("s5_d0", 4'b1110, 8'h99, 1'b1);
    scan_digit("s5_d1", 4'b1101, 8'h30, 1'b0);
    scan_digit("s5_d2", 4'b1011, 8'hA4, 1'b0);
    scan_digit("s5_d3", 4'b0111, 8'hF9, 1'b0);

    // Second rise lands while already blanking: counter restarts.
    scan = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_off("s6_blank_a");
    scan = 1'b0;
    @(posedge clk); #1;
    chk_off("s6_blank_b");
    scan = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      chk_off("s6_restart");
    end
    @(posedge clk); #1;
    chk_show("s6_d0", 4'b1110, 8'h99, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    scan = 1'b0;
    repeat (20) @(posedge clk);
    #1;

    #2;
    rst = 1'b1;
    #1;
    chk_show("s6_async_rst", 4'hF, 8'hFF, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk_off("s6_reboot");
    end
    @(posedge clk); #1;
    chk_show("s6_reboot_d0", 4'b1110, 8'h99, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    scan_digit("s6_reboot_d1", 4'b1101, 8'h30, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
